// File: rtl/dm_stage.sv
// dm_stage: data-memory stage with word/half/byte stores and width-extended loads.
// Define DM_TRACE_EN to print one trace line per committed store.
module dm_stage #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [1:0]  st_size,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic [31:0] wr_count
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  st_ok;
    logic                  ld_ok;
    logic                  commit;
    logic [31:0]           cur;
    logic [31:0]           merged;
    logic [31:0]           ld_word;
    logic [15:0]           ld_half;
    logic [7:0]            ld_byte;
    logic [31:0]           count_q;

    function automatic logic size_ok(input logic [1:0] sz, input logic [1:0] a);
        logic ok;
        case (sz)
            2'd1:    ok = ~a[0];
            2'd2:    ok = 1'b1;
            default: ok = (a == 2'd0);
        endcase
        return ok;
    endfunction

    assign off      = addr - BASE_ADDR;
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign widx     = off[DEPTH_LOG2+1:2];
    assign lane     = off[1:0];
    assign cur      = mem[widx];

    // Alignment is judged on the raw address, not on the offset.
    assign st_ok = size_ok(st_size, addr[1:0]);
    assign ld_ok = size_ok(ld_size, addr[1:0]);

    assign align_err = mem_write ? ((st_size != 2'd3) && !st_ok) : !ld_ok;
    assign commit    = mem_write && (st_size != 2'd3) && in_range && st_ok;

    always_comb begin
        merged = cur;
        unique case (st_size)
            2'd0: merged = wdata;
            2'd1: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            2'd2:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
            default: merged = cur;
        endcase
    end

    assign ld_half = lane[1] ? cur[31:16] : cur[15:0];
    assign ld_byte = cur[{lane, 3'b000} +: 8];

    always_comb begin
        ld_word = cur;
        unique case (ld_size)
            2'd1:    ld_word = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            2'd2:    ld_word = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            default: ld_word = cur;
        endcase
    end

    assign rdata    = (in_range && ld_ok) ? ld_word : 32'd0;
    assign wr_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
            count_q <= 32'd0;
        end else if (commit) begin
            mem[widx] <= merged;
            count_q   <= count_q + 32'd1;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && commit)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: directed test-plan cases plus random accesses
// checked against a byte-arithmetic memory model.
module tb_dm_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [1:0]  st_size;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        align_err;
    logic [31:0] wr_count;

    int checks   = 0;
    int failures = 0;

    bit [31:0] ref_mem [1024];
    bit [31:0] ref_cnt;

    dm_stage dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .st_size    (st_size),
        .ld_size    (ld_size),
        .ld_unsigned(ld_unsigned),
        .addr       (addr),
        .wdata      (wdata),
        .pc         (pc),
        .rdata      (rdata),
        .align_err  (align_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input bit [1:0] sz);
        if (sz == 2'd1) return 2;
        if (sz == 2'd2) return 1;
        return 4;
    endfunction

    function automatic bit [31:0] exp_load(input bit [31:0] a,
                                           input bit [1:0] sz, input bit u);
        int n;
        bit [31:0] v, m;
        n = nbytes(sz);
        if (a >= 32'd4096) return 0;
        if (a % n != 0) return 0;
        v = ref_mem[a / 4];
        if (n == 4) return v;
        m = (n == 2) ? 32'hFFFF : 32'hFF;
        v = (v >> (8 * (a % 4))) & m;
        if (!u && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~m;
        return v;
    endfunction

    function automatic bit exp_err(input bit mw, input bit [1:0] ss,
                                   input bit [1:0] ls, input bit [31:0] a);
        if (mw) begin
            if (ss == 2'd3) return 0;
            return (a % nbytes(ss)) != 0;
        end
        return (a % nbytes(ls)) != 0;
    endfunction

    task automatic model_edge(input bit mw, input bit [1:0] ss,
                              input bit [31:0] a, input bit [31:0] wd,
                              input bit rs);
        int n;
        bit [31:0] m, sh;
        if (rs) begin
            foreach (ref_mem[i]) ref_mem[i] = 0;
            ref_cnt = 0;
            return;
        end
        if (!mw || ss == 2'd3 || a >= 32'd4096) return;
        n = nbytes(ss);
        if (a % n != 0) return;
        m  = (n == 4) ? 32'hFFFF_FFFF : ((n == 2) ? 32'hFFFF : 32'hFF);
        sh = 8 * (a % 4);
        ref_mem[a / 4] = (ref_mem[a / 4] & ~(m << sh)) | ((wd & m) << sh);
        ref_cnt = ref_cnt + 1;
    endtask

    task automatic access(input bit mw, input bit [1:0] ss, input bit [1:0] ls,
                          input bit u, input bit [31:0] a, input bit [31:0] wd,
                          input bit rs);
        @(negedge clk);
        reset       = rs;
        mem_write   = mw;
        st_size     = ss;
        ld_size     = ls;
        ld_unsigned = u;
        addr        = a;
        wdata       = wd;
        pc          = $urandom;
        #1;
        check("rdata", rdata, exp_load(a, ls, u));
        check("align_err", {31'd0, align_err}, {31'd0, exp_err(mw, ss, ls, a)});
        @(posedge clk);
        model_edge(mw, ss, a, wd, rs);
        #1;
        check("wr_count", wr_count, ref_cnt);
    endtask

    task automatic load(input bit [1:0] ls, input bit u, input bit [31:0] a);
        access(1'b0, 2'd0, ls, u, a, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; mem_write = 1'b0; st_size = 2'd0; ld_size = 2'd0;
        ld_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0; pc = 32'd0;
        foreach (ref_mem[i]) ref_mem[i] = 0;
        ref_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        load(2'd0, 1'b0, 32'h0);
        check("rst_lw0", rdata, 32'h0);
        check("rst_cnt", wr_count, 32'h0);
        load(2'd0, 1'b0, 32'hFFC);
        check("rst_lwffc", rdata, 32'h0);
        check("rst_err", {31'd0, align_err}, 32'h0);

        access(1'b1, 2'd0, 2'd0, 1'b0, 32'h10, 32'h1234_5678, 1'b0);
        load(2'd0, 1'b0, 32'h10);
        check("lw10", rdata, 32'h1234_5678);
        load(2'd1, 1'b0, 32'h12);
        check("lh12", rdata, 32'h0000_1234);
        load(2'd2, 1'b0, 32'h10);
        check("lb10", rdata, 32'h0000_0078);
        load(2'd2, 1'b0, 32'h13);
        check("lb13", rdata, 32'h0000_0012);
        check("cnt1", wr_count, 32'd1);

        access(1'b1, 2'd2, 2'd0, 1'b0, 32'h11, 32'h0000_00F0, 1'b0);
        load(2'd0, 1'b0, 32'h10);
        check("sb_word", rdata, 32'h1234_F078);
        load(2'd2, 1'b0, 32'h11);
        check("lb11", rdata, 32'hFFFF_FFF0);
        load(2'd2, 1'b1, 32'h11);
        check("lbu11", rdata, 32'h0000_00F0);

        access(1'b1, 2'd0, 2'd0, 1'b0, 32'h22, 32'hDEAD_BEEF, 1'b0);
        check("sw22_err", {31'd0, align_err}, 32'd1);
        access(1'b1, 2'd1, 2'd0, 1'b0, 32'h21, 32'hCAFE, 1'b0);
        check("sh21_err", {31'd0, align_err}, 32'd1);
        check("mis_cnt", wr_count, 32'd2);
        load(2'd0, 1'b0, 32'h20);
        check("mis_mem", rdata, 32'h0);
        load(2'd0, 1'b0, 32'h22);
        check("lw22", rdata, 32'h0);
        check("lw22_err", {31'd0, align_err}, 32'd1);

        access(1'b1, 2'd0, 2'd0, 1'b0, 32'h1000, 32'hAAAA_5555, 1'b0);
        check("oor_cnt", wr_count, 32'd2);
        load(2'd0, 1'b0, 32'h0);
        check("oor_w0", rdata, 32'h0);
        load(2'd0, 1'b0, 32'h1000);
        check("lw1000", rdata, 32'h0);

        access(1'b1, 2'd3, 2'd0, 1'b0, 32'h8, 32'h1111_1111, 1'b0);
        check("sz3_err", {31'd0, align_err}, 32'd0);
        check("sz3_cnt", wr_count, 32'd2);

        access(1'b1, 2'd1, 2'd0, 1'b0, 32'h6, 32'h0000_BEEF, 1'b0);
        load(2'd0, 1'b0, 32'h4);
        check("sh6", rdata, 32'hBEEF_0000);

        access(1'b1, 2'd0, 2'd0, 1'b0, 32'h4, 32'h7777_7777, 1'b1);
        load(2'd0, 1'b0, 32'h4);
        check("rst_sw4", rdata, 32'h0);
        load(2'd0, 1'b0, 32'h10);
        check("rst_clr", rdata, 32'h0);
        check("rst_cnt2", wr_count, 32'h0);

        for (int i = 0; i < 600; i++) begin
            bit [31:0] a;
            if ($urandom_range(0, 3) != 0) a = $urandom_range(0, 63);
            else a = $urandom_range(0, 32'h10FF);
            access($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   a, $urandom, $urandom_range(0, 79) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
